// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// -----------------
// Central stall/flush scheduler for the 5-stage pipeline. It sits beside the
// ID stage and looks at ID- and EX-stage fields in the current cycle. It
// detects these conditions:
//   - load-use hazards;
//   - HI/LO occupancy by an in-flight mult/div;
//   - instruction-memory wait states;
//   - taken-branch redirects.
// It then drives the hold/bubble controls of PC, IF/ID and ID/EX.
//
// Optional feature macro: STALL_CNT_EN
//   defined   : stall_cycles counts cycles with ifid_stall high. It saturates
//               at all ones and is cleared only by reset.
//   undefined : no counter flops, and stall_cycles is tied to 0.
//
// Parameters:
//   MD_LATENCY - cycles a mult/div occupies HI/LO after issue (1..63)
//   CNT_W      - width of the stall-cycle performance counter
//
// Ports:
//   clk, rst_n           - clock (rising edge), async active-low reset
//   id_rs, id_rt         - source register fields of the ID instruction
//   id_uses_rs/rt        - ID instruction actually reads rs / rt
//   id_is_muldiv         - ID instruction is mult/multu/div/divu
//   id_reads_hilo        - ID instruction is mfhi/mflo
//   ex_mem_read          - EX instruction is a load
//   ex_rt_dest           - destination register of the EX load
//   ex_branch_taken      - branch/jump resolved taken in EX
//   imem_ready           - instruction memory has valid data this cycle
//   pc_stall, ifid_stall - hold PC / hold IF/ID
//   ifid_flush           - load NOP into IF/ID
//   idex_flush           - load bubble into ID/EX
//   md_busy              - mult/div in progress
//   stall_cycles         - count of cycles with ifid_stall high
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt_dest,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t           state_r;
  md_state_t           state_nxt_s;
  logic [MD_CNT_W-1:0] md_cnt_r;
  logic [MD_CNT_W-1:0] md_cnt_nxt_s;

  logic load_use_s;
  logic md_hazard_s;
  logic md_busy_s;
  logic md_issue_s;

  assign md_busy_s = (state_r == MD_BUSY);

  // A load into $0 never creates a dependency, so it is excluded here.
  assign load_use_s = ex_mem_read && (ex_rt_dest != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rt_dest)) ||
                       (id_uses_rt && (id_rt == ex_rt_dest)));

  assign md_hazard_s = md_busy_s && (id_is_muldiv || id_reads_hilo);

  // A mult/div leaves ID only when it is neither squashed nor held by a
  // load-use. An imem wait does not stop the ID instruction from advancing.
  assign md_issue_s = (state_r == RUN) && id_is_muldiv &&
                      !ex_branch_taken && !load_use_s;

  // Prioritised stall/flush decode. The outputs are gated by rst_n so that
  // they read 0 for the whole time reset is held.
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst_n) begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end else if (ex_branch_taken) begin
      // The ID instruction is wrong-path, so squashing beats any stall.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use_s || md_hazard_s) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end else begin
      pc_stall   = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  assign md_busy = md_busy_s;

  // Mult/div occupancy next-state logic and down-counter.
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    case (state_r)
      RUN: begin
        if (md_issue_s) begin
          state_nxt_s  = MD_BUSY;
          md_cnt_nxt_s = MD_CNT_W'(MD_LATENCY);
        end else begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = {MD_CNT_W{1'b0}};
        end
      end
      MD_BUSY: begin
        if (md_cnt_r == MD_CNT_W'(1)) begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = {MD_CNT_W{1'b0}};
        end else begin
          state_nxt_s  = MD_BUSY;
          md_cnt_nxt_s = md_cnt_r - MD_CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s  = RUN;
        md_cnt_nxt_s = {MD_CNT_W{1'b0}};
      end
    endcase
  end

  // Mult/div state and counter registers. Reset aborts an operation that is
  // still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= RUN;
      md_cnt_r <= {MD_CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
    end
  end

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of IF/ID stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (ifid_stall && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl (MD_LATENCY=4, CNT_W=4).
// The ctrl vector is packed as {pc_stall, ifid_stall, ifid_flush, idex_flush}.
module tb_hazard_stall_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_is_muldiv;
  logic             id_reads_hilo;
  logic             ex_mem_read;
  logic [4:0]       ex_rt_dest;
  logic             ex_branch_taken;
  logic             imem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [3:0] ctrl;
  assign ctrl = {pc_stall, ifid_stall, ifid_flush, idex_flush};

  hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt_dest(ex_rt_dest),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_muldiv = 1'b0; id_reads_hilo = 1'b0;
    ex_mem_read = 1'b0; ex_rt_dest = 5'd0;
    ex_branch_taken = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rt_dest = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    // A hazard that is present while reset is held must still give zeros.
    set_load_use();
    #1;
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_busy", 32'(md_busy), 32'h0);
    check("rst_cnt", 32'(stall_cycles), 32'h0);
    idle_inputs();
    #5 rst_n = 1'b1;

    // Load-use on rs, then drop the load.
    tick(); set_load_use(); #1;
    check("lu_rs", 32'(ctrl), 32'hD);
    tick(); ex_mem_read = 1'b0; #1;
    check("lu_drop", 32'(ctrl), 32'h0);

    // Load-use on rt, then the same match with rt not read.
    tick(); idle_inputs();
    ex_mem_read = 1'b1; ex_rt_dest = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; #1;
    check("lu_rt", 32'(ctrl), 32'hD);
    id_uses_rt = 1'b0; #1;
    check("lu_rt_unused", 32'(ctrl), 32'h0);

    // A load into $0 never stalls.
    tick(); idle_inputs();
    ex_mem_read = 1'b1; ex_rt_dest = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; #1;
    check("lu_zero", 32'(ctrl), 32'h0);

    // Priority: branch over load-use, load-use over imem wait, imem wait alone.
    tick(); idle_inputs(); set_load_use(); ex_branch_taken = 1'b1; #1;
    check("br_over_lu", 32'(ctrl), 32'h3);
    ex_branch_taken = 1'b0; imem_ready = 1'b0; #1;
    check("lu_over_imem", 32'(ctrl), 32'hD);
    tick(); idle_inputs(); imem_ready = 1'b0; #1;
    check("imem_wait", 32'(ctrl), 32'hA);

    // Mult issue at cycle T. mfhi stalls over T+1..T+4, except T+2 carries an add.
    tick(); idle_inputs(); id_is_muldiv = 1'b1; #1;
    check("md_issue_ctrl", 32'(ctrl), 32'h0);
    check("md_issue_busy", 32'(md_busy), 32'h0);
    tick(); idle_inputs(); id_reads_hilo = 1'b1; #1;
    check("md_t1_busy", 32'(md_busy), 32'h1);
    check("md_t1_mfhi", 32'(ctrl), 32'hD);
    tick(); idle_inputs(); id_rs = 5'd3; id_uses_rs = 1'b1; #1;
    check("md_t2_add", 32'(ctrl), 32'h0);
    check("md_t2_busy", 32'(md_busy), 32'h1);
    tick(); idle_inputs(); id_reads_hilo = 1'b1; #1;
    check("md_t3_mfhi", 32'(ctrl), 32'hD);
    tick(); #1;
    check("md_t4_mfhi", 32'(ctrl), 32'hD);
    check("md_t4_busy", 32'(md_busy), 32'h1);
    tick(); #1;
    check("md_t5_release", 32'(ctrl), 32'h0);
    check("md_t5_busy", 32'(md_busy), 32'h0);

    // A mult in ID with a taken branch is squashed and does not issue.
    tick(); idle_inputs(); id_is_muldiv = 1'b1; ex_branch_taken = 1'b1; #1;
    check("md_br_ctrl", 32'(ctrl), 32'h3);
    tick(); idle_inputs(); #1;
    check("md_br_noissue", 32'(md_busy), 32'h0);
    // A mult held by a load-use does not issue either.
    id_is_muldiv = 1'b1; set_load_use(); #1;
    check("md_lu_ctrl", 32'(ctrl), 32'hD);
    tick(); idle_inputs(); #1;
    check("md_lu_noissue", 32'(md_busy), 32'h0);

    // A branch after issue does not cancel the mult/div. A second mult waits.
    id_is_muldiv = 1'b1; #1;
    tick(); idle_inputs(); ex_branch_taken = 1'b1; #1;
    check("md_keep_busy", 32'(md_busy), 32'h1);
    check("md_keep_ctrl", 32'(ctrl), 32'h3);
    tick(); idle_inputs(); id_is_muldiv = 1'b1; #1;
    check("md_second_stall", 32'(ctrl), 32'hD);
    tick(); tick(); #1;
    check("md_second_busy_end", 32'(md_busy), 32'h1);
    tick(); #1;
    check("md_second_run", 32'(md_busy), 32'h0);
    check("md_second_go", 32'(ctrl), 32'h0);
    tick(); idle_inputs(); #1;
    check("md_second_issued", 32'(md_busy), 32'h1);

    // Let the second mult drain, then reset mid-operation when the counter is 2.
    tick(); tick(); tick(); tick(); #1;
    check("drain_idle", 32'(md_busy), 32'h0);
    id_is_muldiv = 1'b1;
    tick(); idle_inputs();   // counter 4
    tick();                  // counter 3
    tick();                  // counter 2
    id_reads_hilo = 1'b1; set_load_use();
    rst_n = 1'b0; #1;
    check("arst_busy", 32'(md_busy), 32'h0);
    check("arst_ctrl", 32'(ctrl), 32'h0);
    check("arst_cnt", 32'(stall_cycles), 32'h0);
    idle_inputs();
    #2 rst_n = 1'b1;
    tick(); idle_inputs(); id_reads_hilo = 1'b1; #1;
    check("post_rst_mfhi", 32'(ctrl), 32'h0);
    check("post_rst_busy", 32'(md_busy), 32'h0);
    check("cnt_start", 32'(stall_cycles), 32'h0);

    // Hold a load-use stall for 20 edges. The counter saturates at 15.
    tick(); idle_inputs(); set_load_use();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) begin
`ifdef STALL_CNT_EN
        check("cnt_5", 32'(stall_cycles), 32'd5);
`else
        check("cnt_5_off", 32'(stall_cycles), 32'd0);
`endif
      end
    end
    check("cnt_stall_ctrl", 32'(ctrl), 32'hD);
`ifdef STALL_CNT_EN
    check("cnt_sat", 32'(stall_cycles), 32'd15);
`else
    check("cnt_sat_off", 32'(stall_cycles), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage pipeline.
- Detects load-use hazards, multi-cycle mult/div occupancy of HI/LO, instruction-memory wait states and taken-branch redirects.
- Drives the hold/bubble controls of the PC register, the IF/ID register (its stall input) and the ID/EX register.
- Sits beside the ID stage; all decisions are made on ID-stage and EX-stage fields in the current cycle.

Parameters:
- MD_LATENCY, 32: cycles a mult/div occupies HI/LO after issue; legal range 1..63.
- CNT_W, 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_muldiv  in  1  ID instruction is mult/multu/div/divu.
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt_dest  in  5  destination register of the EX load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID register.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_flush  out  1  load bubble into ID/EX.
- md_busy  out  1  mult/div in progress.
- stall_cycles  out  CNT_W  count of cycles with ifid_stall high.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n is low:
  - All stall/flush outputs are forced to 0.
  - md_busy = 0, stall_cycles = 0.
  - FSM = RUN, mult/div down-counter = 0.
  - Reset asserted mid mult/div aborts it immediately; no residual stall after release.
- Control outputs are combinational from the current inputs and state; state, counter and stall_cycles are registered. Zero-cycle detection latency.
- load_use is asserted when all of the following hold:
  - ex_mem_read = 1;
  - ex_rt_dest != 0 (a load to $0 never stalls);
  - (id_uses_rs and id_rs == ex_rt_dest) or (id_uses_rt and id_rt == ex_rt_dest).
- md_hazard = md_busy and (id_is_muldiv or id_reads_hilo).
- Priority per cycle (highest first):
  1. ex_branch_taken:
     - ifid_flush = 1, idex_flush = 1, pc_stall = 0, ifid_stall = 0.
     - Overrides every stall, since the ID instruction is wrong-path.
  2. load_use or md_hazard:
     - pc_stall = 1, ifid_stall = 1, idex_flush = 1, ifid_flush = 0.
  3. !imem_ready:
     - pc_stall = 1, ifid_flush = 1, ifid_stall = 0, idex_flush = 0.
  4. Otherwise all four controls are 0.
- Mult/div FSM:
  - States: RUN and MD_BUSY; md_busy = (state == MD_BUSY).
  - Issue: in RUN, id_is_muldiv with no branch flush and no load_use means the instruction advances. On that edge: counter <= MD_LATENCY, state <= MD_BUSY.
  - MD_BUSY: counter decrements each cycle; when counter == 1 the next state is RUN and the counter is 0.
  - Mult/div in ID while in MD_BUSY stalls (md_hazard) and issues on the cycle after the return to RUN.
  - Non-HI/LO instructions proceed freely during MD_BUSY.
  - A branch flush does not cancel an already-issued mult/div.
  - MD_LATENCY = 1 gives exactly one busy cycle.
- Counter width: ceil(log2(MD_LATENCY+1)) bits; unsigned.

Optional Feature:
- Macro: STALL_CNT_EN.
- Defined:
  - stall_cycles increments by 1 on each rising edge where ifid_stall = 1.
  - It saturates at 2^CNT_W-1, with no wrap.
  - It is cleared only by reset.
- Undefined: no counter flops; stall_cycles is tied to 0.

Test Plan:
- ex_mem_read=1, ex_rt_dest=8, id_rs=8, id_uses_rs=1 → pc_stall=ifid_stall=idex_flush=1 for that cycle. Drop ex_mem_read the next cycle → all controls 0.
- Same as the first case but ex_rt_dest=0, id_rs=0 → no stall.
- MD_LATENCY=4: issue mult at cycle T → md_busy=1 for cycles T+1..T+4. mfhi held in ID over T+1..T+4 → ifid_stall=1 each cycle; released at T+5. An unrelated add at T+2 → no stall.
- load_use and ex_branch_taken in the same cycle → ifid_flush=idex_flush=1, pc_stall=ifid_stall=0. imem_ready=0 alone → pc_stall=1, ifid_flush=1.
- Mult issued, rst_n pulsed low at counter=2 → md_busy=0 and all outputs 0 asynchronously. After release, mfhi in ID → no stall.
- With STALL_CNT_EN and CNT_W=4: hold a load_use stall for 20 cycles → stall_cycles=15 (saturated). Without the macro → stall_cycles stays 0.
